// File: rtl/cl_adder_pkg.sv
// Shared constants and helpers for the carry-lookahead adder.
// Group count is rounded up so a partial top group is still instantiated.
package cl_adder_pkg;

    localparam int CLA_GROUP_DEFAULT = 4;

    function automatic int num_groups(input int width, input int group);
        return (width + group - 1) / group;
    endfunction

endpackage

// File: rtl/cla_group.sv
// One lookahead group: flattened carry equations plus group generate/propagate.
// Also reused as the second-level unit that turns group G/P into group carry-ins.
module cla_group #(
    parameter int C_GROUP = 4
) (
    input  logic [C_GROUP-1:0] p,
    input  logic [C_GROUP-1:0] g,
    input  logic               ci,
    output logic [C_GROUP:0]   c,
    output logic               gg,
    output logic               gp
);

    always_comb begin
        logic term;
        c    = '0;
        gg   = 1'b0;
        gp   = &p;
        term = 1'b0;
        c[0] = ci;
        // Each carry is a sum of products over the lower bits, never the previous carry.
        for (int i = 1; i <= C_GROUP; i++) begin
            term = ci;
            for (int k = 0; k < i; k++) term = term & p[k];
            c[i] = term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int k = j + 1; k < i; k++) term = term & p[k];
                c[i] = c[i] | term;
            end
        end
        for (int j = 0; j < C_GROUP; j++) begin
            term = g[j];
            for (int k = j + 1; k < C_GROUP; k++) term = term & p[k];
            gg = gg | term;
        end
    end

endmodule

// File: rtl/cl_adder.sv
// Two-level carry-lookahead adder with a registered (C_WIDTH+1)-bit sum.
// Operands are zero-padded to whole groups; padding bits have g=p=0.
module cl_adder
    import cl_adder_pkg::*;
#(
    parameter int C_WIDTH = 4,
    parameter int C_GROUP = CLA_GROUP_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [C_WIDTH-1:0] a,
    input  logic [C_WIDTH-1:0] b,
    output logic [C_WIDTH:0]   y
);

    localparam int NG = num_groups(C_WIDTH, C_GROUP);
    localparam int PW = NG * C_GROUP;

    logic [PW-1:0]              a_x, b_x, p, g;
    logic [NG-1:0]              grp_g, grp_p;
    logic [NG:0]                grp_c;
    logic [NG-1:0][C_GROUP:0]   gc;
    logic [PW:0]                cy;
    logic [C_WIDTH:0]           sum;
    logic                       lvl2_gg, lvl2_gp;
    logic                       unused_bits;

    assign a_x = PW'(a);
    assign b_x = PW'(b);
    assign g   = a_x & b_x;
    assign p   = a_x ^ b_x;

    cla_group #(.C_GROUP(NG)) u_lvl2 (
        .p  (grp_p),
        .g  (grp_g),
        .ci (1'b0),
        .c  (grp_c),
        .gg (lvl2_gg),
        .gp (lvl2_gp)
    );

    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla_group #(.C_GROUP(C_GROUP)) u_grp (
            .p  (p[k*C_GROUP +: C_GROUP]),
            .g  (g[k*C_GROUP +: C_GROUP]),
            .ci (grp_c[k]),
            .c  (gc[k]),
            .gg (grp_g[k]),
            .gp (grp_p[k])
        );
    end

    always_comb begin
        cy = '0;
        for (int k = 0; k < NG; k++) begin
            for (int i = 0; i < C_GROUP; i++) cy[k*C_GROUP + i] = gc[k][i];
        end
        cy[PW] = gc[NG-1][C_GROUP];
    end

    // Carry-out is the carry into bit C_WIDTH, so padding in a partial top group is ignored.
    assign sum = {cy[C_WIDTH], p[C_WIDTH-1:0] ^ cy[C_WIDTH-1:0]};

    assign unused_bits = ^{cy, p, grp_c[NG], lvl2_gg, lvl2_gp};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) y <= '0;
        else        y <= sum;
    end

endmodule

// File: tb/tb_cl_adder.sv
// Bench for cl_adder: four widths side by side against a plain-arithmetic model.
module tb_cl_adder;

    logic        clk;
    logic        reset;
    logic [3:0]  a4,  b4;
    logic [15:0] a16, b16;
    logic [5:0]  a6,  b6;
    logic [31:0] a32, b32;
    logic [4:0]  y4;
    logic [16:0] y16;
    logic [6:0]  y6;
    logic [32:0] y32;

    int checks = 0;
    int errors = 0;

    cl_adder #(.C_WIDTH(4),  .C_GROUP(4)) u4  (.clk(clk), .reset(reset), .a(a4),  .b(b4),  .y(y4));
    cl_adder #(.C_WIDTH(16), .C_GROUP(4)) u16 (.clk(clk), .reset(reset), .a(a16), .b(b16), .y(y16));
    cl_adder #(.C_WIDTH(6),  .C_GROUP(4)) u6  (.clk(clk), .reset(reset), .a(a6),  .b(b6),  .y(y6));
    cl_adder #(.C_WIDTH(32), .C_GROUP(4)) u32 (.clk(clk), .reset(reset), .a(a32), .b(b32), .y(y32));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic randomize_all();
        a4  = 4'($urandom);  b4  = 4'($urandom);
        a16 = 16'($urandom); b16 = 16'($urandom);
        a6  = 6'($urandom);  b6  = 6'($urandom);
        a32 = $urandom;      b32 = $urandom;
    endtask

    // Model: exact unsigned sum of the operands held across the edge.
    task automatic tick_check(input string tag);
        logic [63:0] e4, e16, e6, e32;
        e4  = 64'(a4)  + 64'(b4);
        e16 = 64'(a16) + 64'(b16);
        e6  = 64'(a6)  + 64'(b6);
        e32 = 64'(a32) + 64'(b32);
        @(posedge clk);
        #1;
        check_val({tag, "_w4"},  64'(y4),  e4);
        check_val({tag, "_w16"}, 64'(y16), e16);
        check_val({tag, "_w6"},  64'(y6),  e6);
        check_val({tag, "_w32"}, 64'(y32), e32);
    endtask

    initial begin
        reset = 1'b0;
        randomize_all();
        #20;
        check_val("rst_w4",  64'(y4),  64'd0);
        check_val("rst_w16", 64'(y16), 64'd0);
        check_val("rst_w6",  64'(y6),  64'd0);
        check_val("rst_w32", 64'(y32), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int bi = 0; bi < 16; bi++) begin
            for (int ai = 0; ai < 16; ai++) begin
                randomize_all();
                a4 = 4'(ai);
                b4 = 4'(bi);
                tick_check("exh");
            end
        end

        a4 = 4'd7; b4 = 4'd9;
        tick_check("a7b9");
        check_val("a7b9_lit", 64'(y4), 64'd16);
        a4 = 4'd15; b4 = 4'd15;
        tick_check("max");
        check_val("max_lit", 64'(y4), 64'd30);
        a4 = 4'd15; b4 = 4'd1;
        tick_check("ones_p1");
        check_val("ones_p1_lit", 64'(y4), 64'd16);
        a4 = 4'd0; b4 = 4'd0;
        tick_check("zero");

        // Mid-cycle asynchronous reset with y holding 30.
        a4 = 4'd15; b4 = 4'd15;
        tick_check("pre_rst");
        #3;
        reset = 1'b0;
        #1;
        check_val("async_clr", 64'(y4), 64'd0);
        for (int n = 0; n < 2; n++) begin
            @(posedge clk);
            #1;
            check_val("held_clr", 64'(y4), 64'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        tick_check("post_rst");
        check_val("post_rst_lit", 64'(y4), 64'd30);

        a16 = 16'hFFFF; b16 = 16'h0001; a6 = 6'd63; b6 = 6'd1;
        tick_check("w16_ffff_1");
        check_val("w16_ffff_1_lit", 64'(y16), 64'h10000);
        check_val("w6_63_1_lit",    64'(y6),  64'd64);
        a16 = 16'h8000; b16 = 16'h8000; a6 = 6'd63; b6 = 6'd63;
        tick_check("w16_8000");
        check_val("w16_8000_lit", 64'(y16), 64'h10000);
        check_val("w6_63_63_lit", 64'(y6),  64'd126);
        a16 = 16'h1234; b16 = 16'h4321; a6 = 6'd32; b6 = 6'd31;
        tick_check("w16_1234");
        check_val("w16_1234_lit", 64'(y16), 64'h05555);
        check_val("w6_32_31_lit", 64'(y6),  64'd63);
        a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001;
        tick_check("w32_ones_p1");
        check_val("w32_ones_p1_lit", 64'(y32), 64'h1_0000_0000);
        a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF;
        tick_check("w32_max");

        for (int n = 0; n < 10000; n++) begin
            randomize_all();
            tick_check("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cl_adder.md
Name: cl_adder

Overview:
Unsigned carry-lookahead adder with a registered sum. It adds two C_WIDTH-bit operands and produces a (C_WIDTH+1)-bit result whose MSB is the carry-out. The block is a generic arithmetic primitive for the synthesizer datapath (e.g. accumulator and mixer sums), where a ripple-carry chain would limit clock rate.

Parameters:
C_WIDTH, 4, operand width in bits; legal range 1..64.
C_GROUP, 4, lookahead group size in bits; the last group may be partial when C_WIDTH is not a multiple of C_GROUP.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
a  input  C_WIDTH  operand A, unsigned.
b  input  C_WIDTH  operand B, unsigned.
y  output  C_WIDTH+1  registered sum a+b; y[C_WIDTH] is the carry-out.

Behaviour:
- One clock, clk; reset is asynchronous and active-low.
- Arithmetic: y = zero-extended a + zero-extended b, exact, with no overflow or wrap. Maximum value is 2*(2^C_WIDTH-1).
- Carry-in is fixed at 0; there is no carry-in port.
- Carry generation: per bit g_i = a_i & b_i and p_i = a_i ^ b_i.
  - Within a group, carries come from lookahead equations (c_{i+1} = g_i | p_i&c_i, expanded), not from a ripple chain.
  - Each group exports group generate G and group propagate P.
  - Inter-group carries are computed from G/P by a second lookahead level (ripple across groups is acceptable only when C_WIDTH/C_GROUP <= 2).
- Sum: s_i = p_i ^ c_i. Carry-out = carry out of the top group.
- Latency: the combinational sum is captured into the y register on every rising clk edge.
  - y reflects the a,b values sampled at edge N, valid after edge N.
  - Latency is exactly 1 cycle. There is no handshake; the register updates every cycle.
- Reset: while reset=0, y=0 asynchronously, regardless of clk.
  - On release, the first rising edge loads a+b.
  - If reset is asserted mid-stream, y clears at once; no earlier sum survives.
- Inputs are sampled only at clock edges. Glitches between edges do not affect y.
- Boundary values:
  - all-ones + all-ones gives carry-out 1 and low bits all-ones-minus-one.
  - all-ones + 1 gives y = 2^C_WIDTH exactly (full carry propagation through every group).
  - 0 + 0 gives 0.
- Partial last group: only its valid bits take part. Unused positions are treated as g=0, p=0 and must not alter the carry-out.

Decomposition:
- Shared package cl_adder_pkg: the default C_GROUP constant, and a function returning the group count, ceil(C_WIDTH/C_GROUP).
- Natural sub-module: cla_group.
  - Inputs: C_GROUP-bit p/g vectors and carry-in.
  - Outputs: internal carries, group G, group P.
  - Instantiated by generate per group. A second-level lookahead unit combines G/P into group carry-ins.
- The output register lives in cl_adder.

Test Plan:
- Exhaustive C_WIDTH=4: hold reset=0 for 20 ns, release, then sweep a 0..15 inner and b 0..15 outer, one pair per cycle. Require y == a+b one cycle after each pair; e.g. a=7,b=9 -> y=16.
- Max operands, C_WIDTH=4: a=15,b=15 -> y=30 (5'b11110) next cycle. Then a=15,b=1 -> y=16 (carry-out 1, low bits 0).
- Reset behaviour: with y=30 held, drive reset=0 between clock edges. y must go to 0 before the next edge and stay 0 while reset=0, even with a=b=15. After release, the first edge gives y=30.
- Wide config C_WIDTH=16, C_GROUP=4:
  - 0xFFFF+0x0001 -> 0x10000.
  - 0x8000+0x8000 -> 0x10000.
  - 0x1234+0x4321 -> 0x05555.
- Partial group C_WIDTH=6, C_GROUP=4: 63+1 -> 64; 63+63 -> 126; 32+31 -> 63.
- Random regression C_WIDTH=32: 10,000 random pairs. The y of each cycle must match the previous cycle's a+b, with a 33-bit compare.
